// File: rtl/mesh_fetch_scheduler.sv
// Per-frame triangle fetch from mesh BRAM, credit-throttled against a small FWFT
// output FIFO and presented as a valid/ready stream tagged with triangle ID.
module mesh_fetch_scheduler #(
  parameter  int MAX_COUNT    = 1024,
  parameter  int DATA_WIDTH   = 144,
  parameter  int READ_LATENCY = 2,
  parameter  int FIFO_DEPTH   = 4,
  localparam int ADDR_WIDTH   = $clog2(MAX_COUNT)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH:0]   num_tris_in,
  output logic                  ram_en_out,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  input  logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [DATA_WIDTH-1:0] tri_data_out,
  output logic [ADDR_WIDTH-1:0] tri_id_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  busy_out,
  output logic                  frame_done_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CRD_W = $clog2(FIFO_DEPTH + READ_LATENCY + 1);
  localparam logic [CNT_W-1:0]    FULL_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CRD_W-1:0]    CREDITS = CRD_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] MAX_C   = (ADDR_WIDTH + 1)'(MAX_COUNT);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   n_tris, issue_cnt, pop_cnt;
  logic                  issue, push, pop;
  logic [CRD_W-1:0]      inflight;
  logic [READ_LATENCY-1:0] vld_p;
  logic [ADDR_WIDTH-1:0] id_p [READ_LATENCY];
  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_id [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      fifo_count;

  function automatic logic [ADDR_WIDTH:0] sat_count(input logic [ADDR_WIDTH:0] n);
    return (n > MAX_C) ? MAX_C : n;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CRD_W'(vld_p[i]);
  end

  // Credits count registered occupancy only; a pop this cycle frees a slot next cycle.
  assign issue = (state == FETCH) && (issue_cnt < n_tris) &&
                 ((inflight + CRD_W'(fifo_count)) < CREDITS);
  assign ram_en_out   = issue;
  assign ram_addr_out = issue_cnt[ADDR_WIDTH-1:0];
  assign push         = vld_p[READ_LATENCY-1];
  assign valid_out    = (fifo_count != '0);
  assign pop          = valid_out && ready_in;
  assign tri_data_out = valid_out ? mem_data[rd_ptr] : '0;
  assign tri_id_out   = valid_out ? mem_id[rd_ptr] : '0;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  // DRAIN looks at the handshake in flight so done lands the cycle after the last pop.
  always_comb begin
    state_nxt      = state;
    busy_out       = 1'b1;
    frame_done_out = 1'b0;
    case (state)
      IDLE: begin
        busy_out = 1'b0;
        if (start_in) state_nxt = FETCH;
      end
      FETCH: if (issue_cnt == n_tris) state_nxt = DRAIN;
      DRAIN: if ((pop_cnt + (ADDR_WIDTH + 1)'(pop)) == n_tris) state_nxt = DONE;
      DONE: begin
        frame_done_out = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      n_tris    <= '0;
      issue_cnt <= '0;
      pop_cnt   <= '0;
    end else if (state == IDLE && start_in) begin
      n_tris    <= sat_count(num_tris_in);
      issue_cnt <= '0;
      pop_cnt   <= '0;
    end else begin
      if (issue) issue_cnt <= issue_cnt + CNT_ONE;
      if (pop)   pop_cnt   <= pop_cnt + CNT_ONE;
    end
  end

  // Stage p0..pN: in-flight reads, aligned with BRAM read latency
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vld_p <= '0;
      for (int i = 0; i < READ_LATENCY; i++) id_p[i] <= '0;
    end else begin
      vld_p[0] <= issue;
      id_p[0]  <= issue_cnt[ADDR_WIDTH-1:0];
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        id_p[i]  <= id_p[i-1];
      end
    end
  end

  // Output FIFO: returned data and tag captured as they emerge from the pipe
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_data[wr_ptr] <= ram_data_in;
      mem_id[wr_ptr]   <= id_p[READ_LATENCY-1];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_in)
    !(push && fifo_count == FULL_C));

endmodule

// File: tb/tb_mesh_fetch_scheduler.sv
// Bench for mesh_fetch_scheduler: BRAM model with fixed read latency plus a
// frame-level reference (in-order IDs, credit limit, timing) checked per scenario.
module tb_mesh_fetch_scheduler;
  localparam int MAXC  = 1024;
  localparam int AW    = 10;
  localparam int DW    = 144;
  localparam int DEPTH = 4;
  localparam logic [DW-1:0] GARB = {9{16'hDEAD}};

  logic          clk_in = 1'b0;
  logic          rst_in, start_in, ready_in;
  logic [AW:0]   num_tris_in;
  logic          ram_en_out;
  logic [AW-1:0] ram_addr_out;
  logic [DW-1:0] ram_data_in, tri_data_out;
  logic [AW-1:0] tri_id_out;
  logic          valid_out, busy_out, frame_done_out;

  always #5 clk_in = ~clk_in;

  mesh_fetch_scheduler #(.MAX_COUNT(MAXC), .DATA_WIDTH(DW), .READ_LATENCY(2), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .num_tris_in(num_tris_in),
    .ram_en_out(ram_en_out), .ram_addr_out(ram_addr_out), .ram_data_in(ram_data_in),
    .tri_data_out(tri_data_out), .tri_id_out(tri_id_out), .valid_out(valid_out),
    .ready_in(ready_in), .busy_out(busy_out), .frame_done_out(frame_done_out));

  function automatic logic [DW-1:0] word(input int a);
    logic [DW-1:0] w;
    for (int k = 0; k < 9; k++) w[k*16 +: 16] = 16'(a * 40503 + k * 4099 + 7);
    return w;
  endfunction

  // BRAM model: data for an address issued in cycle t is presented in cycle t+2
  logic          en_d1 = 1'b0, en_d2 = 1'b0;
  logic [AW-1:0] a_d1 = '0, a_d2 = '0;
  always @(posedge clk_in) begin
    en_d1 <= ram_en_out; a_d1 <= ram_addr_out;
    en_d2 <= en_d1;      a_d2 <= a_d1;
  end
  assign ram_data_in = en_d2 ? word(int'(a_d2)) : GARB;

  int errors = 0, checks = 0;
  int cyc, n_frame, n_iss, n_hs, max_out, missed, unstable, done_cnt, done_cyc, busy_cnt;
  logic prev_stall;
  logic [AW-1:0] prev_id;
  logic [DW-1:0] prev_data;
  int addr_q[$], iss_cyc_q[$], id_q[$], hs_cyc_q[$];
  logic [DW-1:0] data_q[$];

  task automatic clear_obs();
    cyc = 0; n_iss = 0; n_hs = 0; max_out = 0; missed = 0; unstable = 0;
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; prev_stall = 1'b0;
    addr_q.delete(); iss_cyc_q.delete(); id_q.delete(); hs_cyc_q.delete(); data_q.delete();
  endtask

  // One clock of observation: records issues, handshakes and frame status
  task automatic step(input logic rdy);
    @(negedge clk_in);
    start_in = 1'b0;
    ready_in = rdy;
    cyc++;
    if (prev_stall && (!valid_out || tri_id_out != prev_id || tri_data_out != prev_data)) unstable++;
    prev_stall = valid_out && !ready_in;
    prev_id = tri_id_out; prev_data = tri_data_out;
    if (ram_en_out) begin
      if (n_iss - n_hs > max_out) max_out = n_iss - n_hs;
      addr_q.push_back(int'(ram_addr_out)); iss_cyc_q.push_back(cyc); n_iss++;
    end else if (busy_out && n_iss < n_frame && (n_iss - n_hs) < DEPTH) missed++;
    if (valid_out && ready_in) begin
      id_q.push_back(int'(tri_id_out)); data_q.push_back(tri_data_out);
      hs_cyc_q.push_back(cyc); n_hs++;
    end
    if (frame_done_out) begin done_cnt++; done_cyc = cyc; end
    if (busy_out) busy_cnt++;
  endtask

  task automatic start_frame(input int n, input logic rdy);
    @(negedge clk_in);
    clear_obs();
    start_in = 1'b1; num_tris_in = (AW+1)'(n); ready_in = rdy;
    n_frame = (n > MAXC) ? MAXC : n;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_in);
    checks++; if (valid_out !== 1'b0 || busy_out !== 1'b0) begin
      errors++; $display("FAIL por_outputs: valid=%b busy=%b, want 0 0", valid_out, busy_out); end
    rst_in = 1'b1;
    start_frame(8, 1'b0);
    repeat (3) step(1'b0);
    checks++; if (n_iss !== 3) begin
      errors++; $display("FAIL rst_pre_issued: got %0d want 3", n_iss); end
    rst_in = 1'b0;
    #1;
    checks++; if (ram_en_out !== 1'b0) begin errors++; $display("FAIL rst_en: got %b want 0", ram_en_out); end
    checks++; if (ram_addr_out !== '0) begin errors++; $display("FAIL rst_addr: got %0d want 0", ram_addr_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid_out); end
    checks++; if (tri_data_out !== '0) begin errors++; $display("FAIL rst_data: got %h want 0", tri_data_out); end
    checks++; if (tri_id_out !== '0) begin errors++; $display("FAIL rst_id: got %0d want 0", tri_id_out); end
    checks++; if (busy_out !== 1'b0 || frame_done_out !== 1'b0) begin
      errors++; $display("FAIL rst_busy_done: got %b %b want 0 0", busy_out, frame_done_out); end
    @(negedge clk_in); @(negedge clk_in);
    rst_in = 1'b1;
    clear_obs(); n_frame = 0;
    repeat (8) step(1'b1);
    checks++; if (n_hs !== 0 || n_iss !== 0 || busy_cnt !== 0) begin
      errors++; $display("FAIL rst_stale: hs=%0d iss=%0d busy=%0d want 0 0 0", n_hs, n_iss, busy_cnt); end
  endtask

  task automatic test_basic();
    start_frame(5, 1'b1);
    repeat (14) step(1'b1);
    checks++; if (n_iss !== 5 || n_hs !== 5) begin
      errors++; $display("FAIL basic_counts: iss=%0d hs=%0d want 5 5", n_iss, n_hs); end
    for (int i = 0; i < 5 && i < n_iss && i < n_hs; i++) begin
      checks++; if (addr_q[i] != i || iss_cyc_q[i] != i + 1) begin
        errors++; $display("FAIL basic_issue%0d: addr=%0d cyc=%0d want %0d %0d", i, addr_q[i], iss_cyc_q[i], i, i + 1); end
      checks++; if (id_q[i] != i || hs_cyc_q[i] != i + 4 || data_q[i] !== word(i)) begin
        errors++; $display("FAIL basic_out%0d: id=%0d cyc=%0d want %0d %0d", i, id_q[i], hs_cyc_q[i], i, i + 4); end
    end
    checks++; if (done_cnt !== 1 || done_cyc !== 9 || busy_cnt !== 9) begin
      errors++; $display("FAIL basic_done: cnt=%0d cyc=%0d busy=%0d want 1 9 9", done_cnt, done_cyc, busy_cnt); end
  endtask

  task automatic test_backpressure();
    start_frame(8, 1'b0);
    repeat (20) step(1'b0);
    checks++; if (n_iss !== DEPTH || max_out >= DEPTH) begin
      errors++; $display("FAIL bp_issued: got %0d (max_out %0d) want %0d", n_iss, max_out, DEPTH); end
    checks++; if (valid_out !== 1'b1 || tri_id_out !== '0 || tri_data_out !== word(0) || unstable !== 0) begin
      errors++; $display("FAIL bp_hold: valid=%b id=%0d unstable=%0d want 1 0 0", valid_out, tri_id_out, unstable); end
    while (done_cnt == 0 && cyc < 80) step(1'b1);
    checks++; if (n_hs !== 8 || n_iss !== 8 || done_cnt !== 1) begin
      errors++; $display("FAIL bp_counts: hs=%0d iss=%0d done=%0d want 8 8 1", n_hs, n_iss, done_cnt); end
    for (int i = 0; i < 8 && i < n_hs && i < n_iss; i++) begin
      checks++; if (id_q[i] != i || data_q[i] !== word(i) || addr_q[i] != i) begin
        errors++; $display("FAIL bp_order%0d: id=%0d addr=%0d want %0d", i, id_q[i], addr_q[i], i); end
    end
    step(1'b1);
  endtask

  task automatic test_zero();
    start_frame(0, 1'b1);
    repeat (6) step(1'b1);
    checks++; if (n_iss !== 0 || n_hs !== 0) begin
      errors++; $display("FAIL zero_reads: iss=%0d hs=%0d want 0 0", n_iss, n_hs); end
    checks++; if (done_cnt !== 1 || done_cyc !== 3 || busy_cnt !== 3) begin
      errors++; $display("FAIL zero_done: cnt=%0d cyc=%0d busy=%0d want 1 3 3", done_cnt, done_cyc, busy_cnt); end
  endtask

  task automatic test_random_full();
    int bad_id, bad_addr;
    start_frame(MAXC, 1'($urandom_range(0, 1)));
    while (done_cnt == 0 && cyc < 12000) step(1'($urandom_range(0, 1)));
    bad_id = 0; bad_addr = 0;
    foreach (id_q[i]) if (id_q[i] != i || data_q[i] !== word(i)) bad_id++;
    foreach (addr_q[i]) if (addr_q[i] != i) bad_addr++;
    checks++; if (n_hs !== MAXC || n_iss !== MAXC || done_cnt !== 1) begin
      errors++; $display("FAIL rand_counts: hs=%0d iss=%0d done=%0d want %0d %0d 1", n_hs, n_iss, done_cnt, MAXC, MAXC); end
    checks++; if (bad_id !== 0 || bad_addr !== 0) begin
      errors++; $display("FAIL rand_order: bad_ids=%0d bad_addrs=%0d want 0 0", bad_id, bad_addr); end
    checks++; if (max_out >= DEPTH || missed !== 0 || unstable !== 0) begin
      errors++; $display("FAIL rand_credit: max_out=%0d missed=%0d unstable=%0d want <%0d 0 0", max_out, missed, unstable, DEPTH); end
    step(1'b1);
  endtask

  task automatic test_clamp();
    start_frame(2047, 1'b1);
    while (done_cnt == 0 && cyc < 3000) step(1'b1);
    checks++; if (n_iss !== MAXC || n_hs !== MAXC || done_cnt !== 1) begin
      errors++; $display("FAIL clamp_counts: iss=%0d hs=%0d done=%0d want %0d %0d 1", n_iss, n_hs, done_cnt, MAXC, MAXC); end
    checks++; if (n_iss > 0 && addr_q[n_iss-1] != MAXC - 1) begin
      errors++; $display("FAIL clamp_last_addr: got %0d want %0d", addr_q[n_iss-1], MAXC - 1); end
    checks++; if (done_cyc !== MAXC + 4) begin
      errors++; $display("FAIL clamp_done_cyc: got %0d want %0d", done_cyc, MAXC + 4); end
    step(1'b1);
  endtask

  task automatic test_start_ignored();
    start_frame(6, 1'b1);
    step(1'b1); step(1'b1);
    start_in = 1'b1; num_tris_in = (AW+1)'(9);
    repeat (16) step(1'b1);
    checks++; if (n_iss !== 6 || n_hs !== 6 || done_cnt !== 1) begin
      errors++; $display("FAIL ign_counts: iss=%0d hs=%0d done=%0d want 6 6 1", n_iss, n_hs, done_cnt); end
    for (int i = 0; i < 6 && i < n_hs && i < n_iss; i++) begin
      checks++; if (id_q[i] != i || addr_q[i] != i || data_q[i] !== word(i)) begin
        errors++; $display("FAIL ign_order%0d: id=%0d addr=%0d want %0d", i, id_q[i], addr_q[i], i); end
    end
    checks++; if (done_cyc !== 10 || busy_cnt !== 10) begin
      errors++; $display("FAIL ign_done: cyc=%0d busy=%0d want 10 10", done_cyc, busy_cnt); end
  endtask

  initial begin
    rst_in = 1'b0; start_in = 1'b0; ready_in = 1'b0; num_tris_in = '0;
    clear_obs(); n_frame = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_random_full();
    test_clamp();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
